// File: rtl/chip8_pkg.sv
// Shared geometry, FSM encoding and pixel indexing for the CHIP-8 sprite engine.
package chip8_pkg;
  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;
  localparam int FB_BITS  = SCREEN_W * SCREEN_H;
  localparam int ADDR_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } draw_state_e;

  function automatic logic [10:0] idx(input logic [5:0] x, input logic [4:0] y);
    return 11'(y) * 11'(SCREEN_W) + 11'(x);
  endfunction
endpackage

// File: rtl/chip8_row_mask.sv
// Turns one sprite byte at (x0,row) into a full-framebuffer XOR mask,
// either clipping or wrapping pixels that fall off the right/bottom edge.
module chip8_row_mask
  import chip8_pkg::*;
#(
  parameter bit CLIP_EN = 1'b1
) (
  input  logic [7:0]         data,
  input  logic [5:0]         x0,
  input  logic [5:0]         row,
  output logic [FB_BITS-1:0] mask
);
  logic [6:0] col;
  logic       keep;

  always_comb begin
    mask = '0;
    col  = '0;
    keep = 1'b0;
    // Bit 7 is the leftmost pixel, so offset j maps to data bit 7-j.
    for (int j = 0; j < 8; j++) begin
      col  = 7'(x0) + 7'(j);
      keep = CLIP_EN ? !(col[6] || row[5]) : 1'b1;
      if (data[7-j] && keep) begin
        mask[idx(col[5:0], row[4:0])] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN / 00E0 engine: fetches sprite rows from memory and XORs them
// into the owned 64x32 framebuffer, reporting the VF collision flag.
module chip8_sprite_draw
  import chip8_pkg::*;
#(
  parameter bit CLIP_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cls,
  input  logic [7:0]         draw_x,
  input  logic [7:0]         draw_y,
  input  logic [3:0]         draw_n,
  input  logic [11:0]        i_addr,
  output logic [11:0]        mem_addr,
  output logic               mem_rd_en,
  input  logic [7:0]         mem_data,
  output logic               busy,
  output logic               done,
  output logic               collision,
  output logic [FB_BITS-1:0] display
);
  draw_state_e        state_q, state_d;
  logic [5:0]         x0_q;
  logic [4:0]         y0_q;
  logic [3:0]         n_q, r_q, r_next;
  logic [ADDR_W-1:0]  i_q;
  logic               collision_q;
  logic [FB_BITS-1:0] fb_q, mask;
  logic [5:0]         row;
  logic               unused_bits;

  // Coordinates are taken modulo the screen, so the upper VX/VY bits never matter.
  assign unused_bits = ^{draw_x[7:6], draw_y[7:5]};

  assign r_next = r_q + 4'd1;
  assign row    = 6'(y0_q) + 6'(r_q);

  chip8_row_mask #(.CLIP_EN(CLIP_EN)) u_row_mask (
    .data (mem_data),
    .x0   (x0_q),
    .row  (row),
    .mask (mask)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cls)        state_d = DONE;
        else if (start) state_d = (draw_n == 4'd0) ? DONE : FETCH;
      end
      FETCH:   state_d = DRAW;
      DRAW:    state_d = (r_next == n_q) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      i_q         <= '0;
      r_q         <= '0;
      collision_q <= 1'b0;
      fb_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cls) begin
            fb_q <= '0;
          end else if (start) begin
            x0_q        <= draw_x[5:0];
            y0_q        <= draw_y[4:0];
            n_q         <= draw_n;
            i_q         <= i_addr;
            r_q         <= '0;
            collision_q <= 1'b0;
          end
        end
        DRAW: begin
          // Whole row commits on one edge; collision sees the pre-XOR pixels.
          fb_q        <= fb_q ^ mask;
          collision_q <= collision_q | (|(mask & fb_q));
          r_q         <= r_next;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == FETCH) || (state_q == DRAW);
  assign done      = (state_q == DONE);
  assign mem_rd_en = (state_q == FETCH);
  assign mem_addr  = mem_rd_en ? (i_q + ADDR_W'(r_q)) : '0;
  assign collision = collision_q;
  assign display   = fb_q;
endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Bench for chip8_sprite_draw: a clipping and a wrapping instance share stimulus
// and are compared against a pixel-level reference model of DXYN/00E0.
module tb_chip8_sprite_draw;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, cls;
  logic [7:0]  draw_x, draw_y;
  logic [3:0]  draw_n;
  logic [11:0] i_addr;
  logic [11:0] mem_addr_c, mem_addr_w;
  logic        mem_rd_en_c, mem_rd_en_w;
  logic [7:0]  mem_data_c, mem_data_w;
  logic        busy_c, busy_w, done_c, done_w, collision_c, collision_w;
  logic [2047:0] display_c, display_w;

  logic [7:0] mem [0:4095];

  chip8_sprite_draw #(.CLIP_EN(1'b1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .cls(cls),
    .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .i_addr(i_addr),
    .mem_addr(mem_addr_c), .mem_rd_en(mem_rd_en_c), .mem_data(mem_data_c),
    .busy(busy_c), .done(done_c), .collision(collision_c), .display(display_c)
  );

  chip8_sprite_draw #(.CLIP_EN(1'b0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .cls(cls),
    .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .i_addr(i_addr),
    .mem_addr(mem_addr_w), .mem_rd_en(mem_rd_en_w), .mem_data(mem_data_w),
    .busy(busy_w), .done(done_w), .collision(collision_w), .display(display_w)
  );

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) begin
    mem_data_c <= mem[mem_addr_c];
    mem_data_w <= mem[mem_addr_w];
  end

  int errors = 0;
  int checks = 0;
  logic [2047:0] ref_c, ref_w;
  logic          coll_c, coll_w;
  logic [11:0]   exp_q[$];

  typedef struct {
    int          x;
    int          y;
    int          n;
    int          ibase;
    bit          cls_first;
    bit          coll;
    logic [2047:0] disp_c;
    logic [2047:0] disp_w;
  } vec_t;
  vec_t vecs[4];

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_fb(input string name, input logic [2047:0] got, input logic [2047:0] want);
    int first;
    checks++;
    if (got !== want) begin
      errors++;
      first = 0;
      for (int i = 2047; i >= 0; i--) if (got[i] !== want[i]) first = i;
      $display("FAIL %s: bit %0d got %b want %b (lit got %0d want %0d)",
               name, first, got[first], want[first], $countones(got), $countones(want));
    end
  endtask

  // Reference: apply the DXYN rules pixel by pixel with plain arithmetic.
  task automatic model_draw(input int x, input int y, input int n, input int ibase);
    logic [7:0] b;
    int c, row, p;
    coll_c = 1'b0;
    coll_w = 1'b0;
    for (int r = 0; r < n; r++) begin
      b = mem[(ibase + r) % 4096];
      for (int k = 0; k < 8; k++) begin
        if (b[7-k]) begin
          c   = (x % 64) + k;
          row = (y % 32) + r;
          p   = (row % 32) * 64 + (c % 64);
          coll_w   = coll_w | ref_w[p];
          ref_w[p] = ~ref_w[p];
          if (c < 64 && row < 32) begin
            coll_c   = coll_c | ref_c[p];
            ref_c[p] = ~ref_c[p];
          end
        end
      end
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic do_draw(input int x, input int y, input int n, input int ibase);
    int edges, rd;
    bit seen;
    logic [11:0] want_addr;
    model_draw(x, y, n, ibase);
    exp_q.delete();
    for (int r = 0; r < n; r++) exp_q.push_back(12'((ibase + r) % 4096));
    draw_x = 8'(x); draw_y = 8'(y); draw_n = 4'(n); i_addr = 12'(ibase);
    start = 1'b1;
    edges = 0; rd = 0; seen = 0;
    while (!seen && edges < 64) begin
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (edges == 1) check_val("busy_after_start", 32'(busy_c), 32'(n != 0));
      if (mem_rd_en_c) begin
        rd++;
        want_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
        check_val("mem_addr", 32'(mem_addr_c), 32'(want_addr));
      end
      if (mem_rd_en_w) check_val("mem_addr_wrap", 32'(mem_addr_w), 32'(mem_addr_c));
      if (done_c) seen = 1;
    end
    check_val("done_latency", 32'(edges), 32'(2 * n + 1));
    check_val("rd_pulses", 32'(rd), 32'(n));
    check_val("busy_in_done", 32'(busy_c), 32'd0);
    check_val("done_wrap", 32'(done_w), 32'd1);
    check_val("collision_clip", 32'(collision_c), 32'(coll_c));
    check_val("collision_wrap", 32'(collision_w), 32'(coll_w));
    check_fb("display_clip", display_c, ref_c);
    check_fb("display_wrap", display_w, ref_w);
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(done_c), 32'd0);
  endtask

  task automatic do_cls();
    cls = 1'b1;
    @(posedge clk); #1;
    cls = 1'b0;
    ref_c = '0;
    ref_w = '0;
    check_val("cls_done", 32'(done_c), 32'd1);
    check_val("cls_busy", 32'(busy_c), 32'd0);
    check_fb("cls_display", display_c, ref_c);
    check_fb("cls_display_wrap", display_w, ref_w);
    check_val("cls_keeps_collision", 32'(collision_c), 32'(coll_c));
    @(posedge clk); #1;
    check_val("cls_done_one_cycle", 32'(done_c), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad_busy, bad_rd, bad_done;
    int x, y, n, ib;

    reset = 1'b1; start = 1'b0; cls = 1'b0;
    draw_x = '0; draw_y = '0; draw_n = '0; i_addr = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    ref_c = '0; ref_w = '0; coll_c = 1'b0; coll_w = 1'b0;

    repeat (2) @(posedge clk); #1;
    check_fb("reset_display", display_c, '0);
    check_val("reset_busy", 32'(busy_c), 32'd0);
    check_val("reset_done", 32'(done_c), 32'd0);
    check_val("reset_collision", 32'(collision_c), 32'd0);
    check_val("reset_rd_en", 32'(mem_rd_en_c), 32'd0);
    check_val("reset_mem_addr", 32'(mem_addr_c), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table: sprite "0", redraw (erase), wrapped coordinates, edge clip/wrap.
    mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
    mem[12'h010] = 8'hFF;
    mem[12'h020] = 8'hFF; mem[12'h021] = 8'hFF;
    vecs[0] = '{0, 0, 5, 0, 1'b0, 1'b0, '0, '0};
    for (int i = 0; i < 4; i++) begin
      vecs[0].disp_c[i] = 1'b1;
      vecs[0].disp_c[256 + i] = 1'b1;
    end
    for (int r = 1; r < 4; r++) begin
      vecs[0].disp_c[r * 64] = 1'b1;
      vecs[0].disp_c[r * 64 + 3] = 1'b1;
    end
    vecs[0].disp_w = vecs[0].disp_c;
    vecs[1] = '{0, 0, 5, 0, 1'b0, 1'b1, '0, '0};
    vecs[2] = '{70, 33, 1, 12'h010, 1'b0, 1'b0, '0, '0};
    for (int i = 70; i < 78; i++) vecs[2].disp_c[i] = 1'b1;
    vecs[2].disp_w = vecs[2].disp_c;
    vecs[3] = '{60, 31, 2, 12'h020, 1'b1, 1'b0, '0, '0};
    for (int i = 0; i < 4; i++) begin
      vecs[3].disp_c[2044 + i] = 1'b1;
      vecs[3].disp_w[2044 + i] = 1'b1;
      vecs[3].disp_w[1984 + i] = 1'b1;
      vecs[3].disp_w[60 + i]   = 1'b1;
      vecs[3].disp_w[i]        = 1'b1;
    end

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].cls_first) do_cls();
      do_draw(vecs[v].x, vecs[v].y, vecs[v].n, vecs[v].ibase);
      check_val("table_collision", 32'(collision_c), 32'(vecs[v].coll));
      check_fb("table_display_clip", display_c, vecs[v].disp_c);
      check_fb("table_display_wrap", display_w, vecs[v].disp_w);
    end

    // Force collision=1, then an n=0 draw must clear it without touching memory.
    do_draw(60, 31, 2, 12'h020);
    check_val("redraw_collision", 32'(collision_c), 32'd1);
    do_draw(5, 5, 0, 0);
    check_val("n0_collision", 32'(collision_c), 32'd0);

    // cls and start together: clear wins, no draw follows.
    do_draw(0, 0, 5, 0);
    draw_x = 8'd3; draw_y = 8'd4; draw_n = 4'd3; i_addr = 12'h000;
    cls = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cls = 1'b0; start = 1'b0;
    ref_c = '0; ref_w = '0;
    check_val("cls_start_done", 32'(done_c), 32'd1);
    bad_busy = 0; bad_rd = 0; bad_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy_c) bad_busy = 1;
      if (mem_rd_en_c) bad_rd = 1;
      if (done_c) bad_done = 1;
    end
    check_val("cls_start_no_busy", 32'(bad_busy), 32'd0);
    check_val("cls_start_no_rd", 32'(bad_rd), 32'd0);
    check_val("cls_start_single_done", 32'(bad_done), 32'd0);
    check_fb("cls_start_display", display_c, ref_c);
    check_val("cls_start_collision", 32'(collision_c), 32'(coll_c));

    // Randomized draws against the model, with occasional clears.
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(0, 255));
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) do_cls();
      x  = $urandom_range(0, 255);
      y  = $urandom_range(0, 255);
      n  = $urandom_range(0, 15);
      ib = (t % 5 == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095);
      do_draw(x, y, n, ib);
    end

    // Reset in the DRAW cycle of the third row abandons everything.
    do_cls();
    mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
    draw_x = 8'd10; draw_y = 8'd3; draw_n = 4'd5; i_addr = 12'h000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_val("pre_reset_busy", 32'(busy_c), 32'd1);
    check_val("pre_reset_lit", 32'(display_c != '0), 32'd1);
    #2 reset = 1'b1;
    #1;
    ref_c = '0; ref_w = '0; coll_c = 1'b0; coll_w = 1'b0;
    check_fb("async_reset_display", display_c, ref_c);
    check_val("async_reset_busy", 32'(busy_c), 32'd0);
    check_val("async_reset_rd_en", 32'(mem_rd_en_c), 32'd0);
    check_val("async_reset_done", 32'(done_c), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    do_draw(10, 3, 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
